// File: rtl/usbh_report_pkg.sv
// Shared HID joystick report layout for the USB host decoder and device encoder.
// Bit offsets, axis values, hat codes and NES button indices.
package usbh_report_pkg;

  localparam int RPT_ID_LSB  = 0;
  localparam int RPT_X_LSB   = 8;
  localparam int RPT_Y_LSB   = 16;
  localparam int RPT_RX_LSB  = 24;
  localparam int RPT_RY_LSB  = 32;
  localparam int RPT_BTN_A   = 47;
  localparam int RPT_BTN_B   = 48;
  localparam int RPT_TURBO_A = 52;
  localparam int RPT_TURBO_B = 53;
  localparam int RPT_SELECT  = 54;
  localparam int RPT_START   = 55;
  localparam int RPT_HAT_LSB = 60;

  localparam logic [7:0] AXIS_MIN = 8'h00;
  localparam logic [7:0] AXIS_CTR = 8'h80;
  localparam logic [7:0] AXIS_MAX = 8'hFF;

  localparam int NES_A      = 0;
  localparam int NES_B      = 1;
  localparam int NES_SELECT = 2;
  localparam int NES_START  = 3;
  localparam int NES_UP     = 4;
  localparam int NES_DOWN   = 5;
  localparam int NES_LEFT   = 6;
  localparam int NES_RIGHT  = 7;

  typedef enum logic [3:0] {
    HAT_N    = 4'h0,
    HAT_NE   = 4'h1,
    HAT_E    = 4'h2,
    HAT_SE   = 4'h3,
    HAT_S    = 4'h4,
    HAT_SW   = 4'h5,
    HAT_W    = 4'h6,
    HAT_NW   = 4'h7,
    HAT_NONE = 4'hF
  } hat_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_t;

  // Inputs are already resolved: opposing directions never both set.
  function automatic hat_t hat_code(
    input logic u,
    input logic d,
    input logic l,
    input logic r
  );
    hat_t h;
    h = HAT_NONE;
    case ({u, d, l, r})
      4'b1000: h = HAT_N;
      4'b1001: h = HAT_NE;
      4'b0001: h = HAT_E;
      4'b0101: h = HAT_SE;
      4'b0100: h = HAT_S;
      4'b0110: h = HAT_SW;
      4'b0010: h = HAT_W;
      4'b1010: h = HAT_NW;
      default: h = HAT_NONE;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus per-bit consecutive-tick debounce counter.
// All bits share one external sample tick.
module btn_debounce #(
  parameter int width = 10,
  parameter int n     = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_tick,
  input  logic [width-1:0] i_raw,
  output logic [width-1:0] o_db
);

  localparam logic [3:0] LAST = 4'(n - 1);

  logic [width-1:0] s1;
  logic [width-1:0] s2;
  logic [width-1:0] db;
  logic [3:0]       cnt [width];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      s1  <= '0;
      s2  <= '0;
      db  <= '0;
      cnt <= '{default: '0};
    end else begin
      s1 <= i_raw;
      s2 <= s1;
      if (i_tick) begin
        for (int i = 0; i < width; i++) begin
          if (s2[i] != db[i]) begin
            if (cnt[i] == LAST) begin
              db[i]  <= ~db[i];
              cnt[i] <= '0;
            end else begin
              cnt[i] <= cnt[i] + 4'd1;
            end
          end else begin
            cnt[i] <= '0;
          end
        end
      end
    end
  end

  assign o_db = db;

endmodule

// File: rtl/usbd_report_encoder.sv
// NES button state to Saitek P3600-style 64-bit HID report, sent on change
// and periodically when idle, over a valid/ready handshake.
module usbd_report_encoder #(
  parameter int         c_clk_hz      = 6000000,
  parameter int         c_debounce_hz = 1000,
  parameter int         c_debounce_n  = 3,
  parameter int         c_idle_hz     = 4,
  parameter logic [7:0] c_report_id   = 8'h00
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_btn,
  input  logic [1:0]  i_turbo,
  output logic [63:0] o_report,
  output logic        o_report_valid,
  input  logic        i_report_ready,
  output logic [7:0]  o_btn_db
);

  import usbh_report_pkg::*;

  localparam int TICK_P = c_clk_hz / c_debounce_hz;
  localparam int IDLE_P = c_clk_hz / c_idle_hz;
  localparam int TW     = $clog2(TICK_P + 1);
  localparam int IW     = $clog2(IDLE_P + 1);

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [9:0]    db;

  assign tick = (tick_cnt == TW'(TICK_P - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)  tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  btn_debounce #(
    .width (10),
    .n     (c_debounce_n)
  ) u_debounce (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_tick  (tick),
    .i_raw   ({i_turbo, i_btn}),
    .o_db    (db)
  );

  assign o_btn_db = db[7:0];

  // Opposing directions cancel to released.
  logic up, down, left, right;
  assign up    = db[NES_UP]    & ~db[NES_DOWN];
  assign down  = db[NES_DOWN]  & ~db[NES_UP];
  assign left  = db[NES_LEFT]  & ~db[NES_RIGHT];
  assign right = db[NES_RIGHT] & ~db[NES_LEFT];

  logic [63:0] enc;

  always_comb begin
    enc = '0;
    enc[RPT_ID_LSB +: 8]  = c_report_id;
    enc[RPT_X_LSB +: 8]   = left ? AXIS_MIN : (right ? AXIS_MAX : AXIS_CTR);
    enc[RPT_Y_LSB +: 8]   = up ? AXIS_MIN : (down ? AXIS_MAX : AXIS_CTR);
    enc[RPT_RX_LSB +: 8]  = AXIS_CTR;
    enc[RPT_RY_LSB +: 8]  = AXIS_CTR;
    enc[RPT_BTN_A]        = db[NES_A];
    enc[RPT_BTN_B]        = db[NES_B];
    enc[RPT_SELECT]       = db[NES_SELECT];
    enc[RPT_START]        = db[NES_START];
    enc[RPT_TURBO_A]      = db[8];
    enc[RPT_TURBO_B]      = db[9];
    enc[RPT_HAT_LSB +: 4] = hat_code(up, down, left, right);
  end

  tx_state_t     state, state_d;
  logic [63:0]   report_q, report_d;
  logic [63:0]   last_q, last_d;
  logic          force_q, force_d;
  logic [IW-1:0] idle_cnt, idle_d;
  logic          idle_exp;

  assign idle_exp = (idle_cnt == IW'(IDLE_P - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= ST_IDLE;
      report_q <= '0;
      last_q   <= '0;
      force_q  <= 1'b1;
      idle_cnt <= '0;
    end else begin
      state    <= state_d;
      report_q <= report_d;
      last_q   <= last_d;
      force_q  <= force_d;
      idle_cnt <= idle_d;
    end
  end

  always_comb begin
    state_d  = state;
    report_d = report_q;
    last_d   = last_q;
    force_d  = force_q;
    idle_d   = idle_cnt;
    unique case (state)
      ST_IDLE: begin
        idle_d = idle_exp ? '0 : idle_cnt + IW'(1);
        if (enc != last_q || idle_exp || force_q) begin
          state_d  = ST_SEND;
          report_d = enc;
          force_d  = 1'b0;
          idle_d   = '0;
        end
      end
      ST_SEND: begin
        if (i_report_ready) begin
          state_d = ST_IDLE;
          last_d  = report_q;
          idle_d  = '0;
        end
      end
    endcase
  end

  assign o_report       = report_q;
  assign o_report_valid = (state == ST_SEND);

endmodule
